// File: rtl/if_fetch_ctrl_if.sv
// rtl/if_fetch_ctrl_if.sv - fetch controller bus: instruction memory, redirect and decode handshake
interface if_fetch_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - PC owner and 2-entry prefetch buffer feeding decode
// Optional halt-on-0xFFFFFFFF detection enabled by macro IF_HALT_DETECT_EN.
module if_fetch_ctrl #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  output logic            busy,
`ifdef IF_HALT_DETECT_EN
  output logic            halted,
`endif
  if_fetch_ctrl_if.master bus
);

`ifdef IF_HALT_DETECT_EN
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STALL, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STALL} state_t;
`endif

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [1:0]        r_count;
  logic [ADDR_W-1:0] r_head_pc;
  logic [DATA_W-1:0] r_head_instr;
  logic [ADDR_W-1:0] r_tail_pc;
  logic [DATA_W-1:0] r_tail_instr;
  logic              r_busy;

  logic              w_pop;
  logic              w_push;
  logic [ADDR_W-1:0] w_redirect_pc;
`ifdef IF_HALT_DETECT_EN
  logic              r_halted;
  logic              w_halt_word;
`endif

  assign w_pop         = (r_count != 2'd0) && bus.out_ready;
  assign w_push        = (r_state == S_FETCH) && !bus.redirect_valid &&
                         ((r_count != 2'd2) || w_pop);
  assign w_redirect_pc = bus.redirect_pc & ~ADDR_W'(3);
`ifdef IF_HALT_DETECT_EN
  assign w_halt_word   = w_push && (bus.imem_rdata == {DATA_W{1'b1}});
  assign halted        = r_halted;
`endif

  assign bus.imem_addr = r_pc;
  assign bus.out_valid = (r_count != 2'd0);
  assign bus.out_instr = r_head_instr;
  assign bus.out_pc    = r_head_pc;
  assign busy          = r_busy;

  // Redirect overrides every state, including IDLE and HALT.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.redirect_valid) begin
      w_state_nxt = enable ? S_FETCH : S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable) w_state_nxt = S_FETCH;
        end
        S_FETCH: begin
`ifdef IF_HALT_DETECT_EN
          if (w_halt_word) w_state_nxt = S_HALT;
          else
`endif
          if (!enable) w_state_nxt = S_IDLE;
          else if ((r_count == 2'd2) && !w_pop) w_state_nxt = S_STALL;
        end
        S_STALL: begin
          if (!enable) w_state_nxt = S_IDLE;
          else if (w_pop) w_state_nxt = S_FETCH;
        end
`ifdef IF_HALT_DETECT_EN
        S_HALT: w_state_nxt = S_HALT;
`endif
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_pc     <= RESET_PC;
`ifdef IF_HALT_DETECT_EN
      r_halted <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_busy   <= (w_state_nxt == S_FETCH) || (w_state_nxt == S_STALL);
`ifdef IF_HALT_DETECT_EN
      r_halted <= (w_state_nxt == S_HALT);
`endif
      if (bus.redirect_valid) begin
        r_pc <= w_redirect_pc;
      end else if (w_push) begin
`ifdef IF_HALT_DETECT_EN
        if (!w_halt_word) r_pc <= r_pc + ADDR_W'(4);
`else
        r_pc <= r_pc + ADDR_W'(4);
`endif
      end
    end
  end

  // Head is always the oldest entry; the tail is only meaningful when count==2.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count      <= 2'd0;
      r_head_pc    <= '0;
      r_head_instr <= '0;
      r_tail_pc    <= '0;
      r_tail_instr <= '0;
    end else if (bus.redirect_valid) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b11: begin
          if (r_count == 2'd2) begin
            r_head_pc    <= r_tail_pc;
            r_head_instr <= r_tail_instr;
            r_tail_pc    <= r_pc;
            r_tail_instr <= bus.imem_rdata;
          end else begin
            r_head_pc    <= r_pc;
            r_head_instr <= bus.imem_rdata;
          end
        end
        2'b10: begin
          if (r_count == 2'd0) begin
            r_head_pc    <= r_pc;
            r_head_instr <= bus.imem_rdata;
            r_count      <= 2'd1;
          end else begin
            r_tail_pc    <= r_pc;
            r_tail_instr <= bus.imem_rdata;
            r_count      <= 2'd2;
          end
        end
        2'b01: begin
          if (r_count == 2'd2) begin
            r_head_pc    <= r_tail_pc;
            r_head_instr <= r_tail_instr;
          end
          r_count <= r_count - 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb/tb_if_fetch_ctrl.sv - directed vector bench for if_fetch_ctrl
module tb_if_fetch_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic busy;
  logic halt_mode = 1'b0;
`ifdef IF_HALT_DETECT_EN
  logic halted;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  if_fetch_ctrl_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  // word[i] = i + 0x100; halt mode plants 0xFFFFFFFF at byte address 0x0C
  assign bus.imem_rdata = (halt_mode && bus.imem_addr == 8'h0C) ? 32'hFFFF_FFFF
                        : 32'h100 + {26'd0, bus.imem_addr[7:2]};

  if_fetch_ctrl #(.ADDR_W(8), .DATA_W(32), .RESET_PC(8'h00)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .busy   (busy),
`ifdef IF_HALT_DETECT_EN
    .halted (halted),
`endif
    .bus    (bus)
  );

  typedef struct {
    logic        rst;
    logic        en;
    logic        rdy;
    logic        rv;
    logic [7:0]  rpc;
    logic        ev;
    logic        cd;
    logic [7:0]  epc;
    logic [31:0] ein;
    logic [7:0]  eaddr;
    logic        ebusy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, en, rdy, rv, input logic [7:0] rpc,
                     input logic ev, cd, input logic [7:0] epc, input logic [31:0] ein,
                     input logic [7:0] eaddr, input logic ebusy);
    vec_t v;
    v.rst = rst; v.en = en; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.cd = cd; v.epc = epc; v.ein = ein; v.eaddr = eaddr; v.ebusy = ebusy;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, en, rdy, rv, input logic [7:0] rpc);
    @(negedge clk);
    reset = rst; enable = en; bus.out_ready = rdy;
    bus.redirect_valid = rv; bus.redirect_pc = rpc;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b0; bus.redirect_pc = 8'h00;

    //   rst en rdy rv rpc    ev cd epc    ein          eaddr  busy
    add(0, 1, 1, 0, 8'h00,  0, 1, 8'h00, 32'h0,       8'h00, 0);
    add(0, 1, 1, 0, 8'h00,  0, 0, 8'h00, 32'h0,       8'h00, 1);
    add(0, 1, 1, 0, 8'h00,  1, 1, 8'h00, 32'h100,     8'h04, 1);
    add(0, 1, 1, 0, 8'h00,  1, 1, 8'h04, 32'h101,     8'h08, 1);
    add(0, 1, 0, 0, 8'h00,  1, 1, 8'h08, 32'h102,     8'h0C, 1);
    add(0, 1, 0, 0, 8'h00,  1, 1, 8'h08, 32'h102,     8'h10, 1);
    add(0, 1, 0, 0, 8'h00,  1, 1, 8'h08, 32'h102,     8'h10, 1);
    add(0, 1, 0, 0, 8'h00,  1, 1, 8'h08, 32'h102,     8'h10, 1);
    add(0, 1, 1, 0, 8'h00,  1, 1, 8'h08, 32'h102,     8'h10, 1);
    add(0, 1, 1, 0, 8'h00,  1, 1, 8'h0C, 32'h103,     8'h10, 1);
    add(0, 1, 0, 0, 8'h00,  1, 1, 8'h10, 32'h104,     8'h14, 1);
    add(0, 1, 0, 1, 8'h43,  1, 1, 8'h10, 32'h104,     8'h18, 1);
    add(0, 1, 1, 0, 8'h00,  0, 0, 8'h00, 32'h0,       8'h40, 1);
    add(0, 1, 1, 1, 8'hF8,  1, 1, 8'h40, 32'h110,     8'h44, 1);
    add(0, 1, 1, 0, 8'h00,  0, 0, 8'h00, 32'h0,       8'hF8, 1);
    add(0, 1, 1, 0, 8'h00,  1, 1, 8'hF8, 32'h13E,     8'hFC, 1);
    add(0, 1, 1, 0, 8'h00,  1, 1, 8'hFC, 32'h13F,     8'h00, 1);
    add(0, 1, 0, 0, 8'h00,  1, 1, 8'h00, 32'h100,     8'h04, 1);
    add(0, 0, 0, 0, 8'h00,  1, 1, 8'h00, 32'h100,     8'h08, 1);
    add(0, 0, 1, 0, 8'h00,  1, 1, 8'h00, 32'h100,     8'h08, 0);
    add(0, 0, 1, 0, 8'h00,  1, 1, 8'h04, 32'h101,     8'h08, 0);
    add(0, 0, 1, 0, 8'h00,  0, 0, 8'h00, 32'h0,       8'h08, 0);
    add(0, 1, 1, 0, 8'h00,  0, 0, 8'h00, 32'h0,       8'h08, 0);
    add(0, 1, 1, 0, 8'h00,  0, 0, 8'h00, 32'h0,       8'h08, 1);
    add(0, 1, 0, 0, 8'h00,  1, 1, 8'h08, 32'h102,     8'h0C, 1);
    add(1, 1, 0, 1, 8'h80,  1, 1, 8'h08, 32'h102,     8'h10, 1);
    add(0, 0, 0, 0, 8'h00,  0, 1, 8'h00, 32'h0,       8'h00, 0);
    add(0, 0, 0, 1, 8'h22,  0, 0, 8'h00, 32'h0,       8'h00, 0);
    add(0, 0, 0, 0, 8'h00,  0, 0, 8'h00, 32'h0,       8'h20, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", -1, {31'd0, bus.out_valid}, 32'd0);
    chk("rst_addr",  -1, {24'd0, bus.imem_addr}, 32'd0);
    chk("rst_busy",  -1, {31'd0, busy}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
      chk("out_valid", i, {31'd0, bus.out_valid}, {31'd0, vecs[i].ev});
      chk("imem_addr", i, {24'd0, bus.imem_addr}, {24'd0, vecs[i].eaddr});
      chk("busy",      i, {31'd0, busy}, {31'd0, vecs[i].ebusy});
      if (vecs[i].cd) begin
        chk("out_pc",    i, {24'd0, bus.out_pc}, {24'd0, vecs[i].epc});
        chk("out_instr", i, bus.out_instr, vecs[i].ein);
      end
    end

`ifdef IF_HALT_DETECT_EN
    halt_mode = 1'b1;
    drive(1, 0, 1, 0, 8'h00);
    drive(0, 1, 1, 0, 8'h00);
    chk("h_idle_halted", 0, {31'd0, halted}, 32'd0);
    drive(0, 1, 1, 0, 8'h00);
    drive(0, 1, 1, 0, 8'h00);
    chk("h_pc0", 2, {24'd0, bus.out_pc}, 32'h00);
    drive(0, 1, 1, 0, 8'h00);
    chk("h_pc4", 3, {24'd0, bus.out_pc}, 32'h04);
    drive(0, 1, 1, 0, 8'h00);
    chk("h_pc8", 4, {24'd0, bus.out_pc}, 32'h08);
    drive(0, 1, 1, 0, 8'h00);
    chk("h_valid",  5, {31'd0, bus.out_valid}, 32'd1);
    chk("h_pcC",    5, {24'd0, bus.out_pc}, 32'h0C);
    chk("h_instr",  5, bus.out_instr, 32'hFFFF_FFFF);
    chk("h_halted", 5, {31'd0, halted}, 32'd1);
    chk("h_busy",   5, {31'd0, busy}, 32'd0);
    chk("h_addr",   5, {24'd0, bus.imem_addr}, 32'h0C);
    drive(0, 1, 1, 1, 8'h20);
    chk("h_drained", 6, {31'd0, bus.out_valid}, 32'd0);
    chk("h_addr",    6, {24'd0, bus.imem_addr}, 32'h0C);
    chk("h_halted",  6, {31'd0, halted}, 32'd1);
    drive(0, 1, 1, 0, 8'h00);
    chk("h_halted",  7, {31'd0, halted}, 32'd0);
    chk("h_addr",    7, {24'd0, bus.imem_addr}, 32'h20);
    chk("h_busy",    7, {31'd0, busy}, 32'd1);
    drive(0, 1, 1, 0, 8'h00);
    chk("h_pc20",    8, {24'd0, bus.out_pc}, 32'h20);
    chk("h_instr20", 8, bus.out_instr, 32'h108);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
